// File: rtl/jtag_tap_pkg.sv
// rtl/jtag_tap_pkg.sv - TAP state encoding and opcode helpers
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'd0,
    RTI      = 4'd1,
    SEL_DR   = 4'd2,
    CAP_DR   = 4'd3,
    SHIFT_DR = 4'd4,
    EX1_DR   = 4'd5,
    PAUSE_DR = 4'd6,
    EX2_DR   = 4'd7,
    UPD_DR   = 4'd8,
    SEL_IR   = 4'd9,
    CAP_IR   = 4'd10,
    SHIFT_IR = 4'd11,
    EX1_IR   = 4'd12,
    PAUSE_IR = 4'd13,
    EX2_IR   = 4'd14,
    UPD_IR   = 4'd15
  } tap_state_e;

  function automatic logic [31:0] bypass_opcode(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state IEEE 1149.1 TAP controller state machine
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tclk,
  input  logic       trst,
  input  logic       tms,
  output logic [3:0] tap_state
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) state_q <= TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = tms ? TLR    : RTI;
      RTI:      state_d = tms ? SEL_DR : RTI;
      SEL_DR:   state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR:   state_d = tms ? EX1_DR : SHIFT_DR;
      SHIFT_DR: state_d = tms ? EX1_DR : SHIFT_DR;
      EX1_DR:   state_d = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_d = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_d = tms ? UPD_DR : SHIFT_DR;
      UPD_DR:   state_d = tms ? SEL_DR : RTI;
      SEL_IR:   state_d = tms ? TLR    : CAP_IR;
      CAP_IR:   state_d = tms ? EX1_IR : SHIFT_IR;
      SHIFT_IR: state_d = tms ? EX1_IR : SHIFT_IR;
      EX1_IR:   state_d = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_d = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_d = tms ? UPD_IR : SHIFT_IR;
      UPD_IR:   state_d = tms ? SEL_DR : RTI;
      default:  state_d = TLR;
    endcase
  end

  assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap_core.sv
// rtl/jtag_tap_core.sv - JTAG TAP with IR, BYPASS, optional IDCODE (TAP_IDCODE_EN) and user-DR select
module jtag_tap_core
  import jtag_tap_pkg::*;
#(
  parameter int unsigned          IR_WIDTH     = 4,
  parameter logic [31:0]          IDCODE_VALUE = 32'h1234_5679,
  parameter logic [IR_WIDTH-1:0]  INSTR_IDCODE = 'h1,
  parameter int unsigned          USER_BASE    = 'h2,
  parameter int unsigned          NUM_USER     = 4
) (
  input  logic                tclk,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                user_sel,
  output logic [2:0]          user_idx,
  input  logic                user_tdo
);

  localparam logic [IR_WIDTH-1:0] BYPASS_OP = IR_WIDTH'(bypass_opcode(IR_WIDTH));
`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_IR = INSTR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RESET_IR = BYPASS_OP;
`endif

  logic [3:0]          state;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_q;
  logic                bypass_q;
  logic                shift_ir;
  logic                dr_lsb;
  logic [31:0]         ir_ext;

  jtag_tap_fsm u_fsm (
    .tclk      (tclk),
    .trst      (trst),
    .tms       (tms),
    .tap_state (state)
  );

  assign tap_state  = state;
  assign capture_dr = (state == CAP_DR);
  assign shift_dr   = (state == SHIFT_DR);
  assign update_dr  = (state == UPD_DR);
  assign shift_ir   = (state == SHIFT_IR);
  assign ir         = ir_q;

  assign ir_ext   = 32'(ir_q);
  assign user_sel = (ir_ext >= USER_BASE) && (ir_ext < USER_BASE + NUM_USER);
  assign user_idx = user_sel ? 3'(ir_ext - USER_BASE) : 3'd0;

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      ir_sr_q  <= '0;
      bypass_q <= 1'b0;
    end else begin
      if (state == CAP_IR) ir_sr_q <= IR_WIDTH'(2'b01);
      else if (shift_ir)   ir_sr_q <= {tdi, ir_sr_q[IR_WIDTH-1:1]};
      if (capture_dr)      bypass_q <= 1'b0;
      else if (shift_dr)   bypass_q <= tdi;
    end
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_q;

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst)           idcode_q <= '0;
    else if (capture_dr) idcode_q <= IDCODE_VALUE;
    else if (shift_dr)   idcode_q <= {tdi, idcode_q[31:1]};
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{INSTR_IDCODE, IDCODE_VALUE};
`endif

  // All-ones wins over every other decode so BYPASS is always reachable.
  always_comb begin
    dr_lsb = bypass_q;
    if (ir_q == BYPASS_OP)         dr_lsb = bypass_q;
`ifdef TAP_IDCODE_EN
    else if (ir_q == INSTR_IDCODE) dr_lsb = idcode_q[0];
`endif
    else if (user_sel)             dr_lsb = user_tdo;
  end

  always_ff @(negedge tclk or negedge trst) begin
    if (!trst) begin
      ir_q   <= RESET_IR;
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      if (state == TLR)         ir_q <= RESET_IR;
      else if (state == UPD_IR) ir_q <= ir_sr_q;
      tdo_en <= shift_dr | shift_ir;
      tdo    <= shift_ir ? ir_sr_q[0] : (shift_dr ? dr_lsb : 1'b0);
    end
  end

endmodule
